// File: rtl/wptr_gray_gen.sv
// Write-side pointer generator for an async FIFO.
// Holds the binary write pointer, publishes a registered Gray pointer to the
// read domain, synchronises the read Gray pointer, and derives full,
// overflow and a pessimistic fill level. Entirely in the write clock domain.
module wptr_gray_gen #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [ADDR_W:0]     rgray_ip,
  output logic [ADDR_W-1:0]   waddr,
  output logic [ADDR_W:0]     wgray_op,
  output logic                wfull,
  output logic                wovf,
  output logic [ADDR_W:0]     wlevel
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wbin_q,  wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] rq1_q,   rq1_d;
  logic [PTR_W-1:0] rq2_q,   rq2_d;
  logic             wfull_q, wfull_d;
  logic             wovf_q,  wovf_d;

  logic             wpush;
  logic [PTR_W-1:0] full_ptr;
  logic [PTR_W-1:0] rbin_sync;

  // Next-state: pointer advance, Gray encode, full/overflow, sync pipeline
  always_comb begin
    wpush    = winc & ~wfull_q;
    wbin_d   = wbin_q + PTR_W'(wpush);
    wgray_d  = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray code that is the read pointer with its two top bits inverted.
    full_ptr = {~rq2_q[PTR_W-1:PTR_W-2], rq2_q[PTR_W-3:0]};
    wfull_d  = (wgray_d == full_ptr);
    wovf_d   = winc & wfull_q;
    rq1_d    = rgray_ip;
    rq2_d    = rq1_q;
  end

  // State registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      wfull_q <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rq1_d;
      rq2_q   <= rq2_d;
      wfull_q <= wfull_d;
      wovf_q  <= wovf_d;
    end
  end

  // Decode the synchronised read pointer and form the write-side fill level
  always_comb begin
    rbin_sync = '0;
    for (int k = 0; k < int'(PTR_W); k++) begin
      rbin_sync[k] = ^(rq2_q >> k);
    end
  end

  assign waddr    = wbin_q[ADDR_W-1:0];
  assign wgray_op = wgray_q;
  assign wfull    = wfull_q;
  assign wovf     = wovf_q;
  assign wlevel   = wbin_q - rbin_sync;

endmodule

// File: doc/wptr_gray_gen.md
Name: wptr_gray_gen

Overview:
Write-side pointer generator for the async FIFO. Maintains the binary write pointer and produces the registered Gray-coded pointer that crosses into the read domain. It also synchronizes the incoming read Gray pointer, and generates the full, overflow and fill-level status. Runs entirely in the write clock domain. It is the encoding counterpart of the read-side Gray decode path.

Parameters:
ADDR_W, 5, FIFO address width; depth = 2^ADDR_W = 32 entries; legal range 2..8.
PTR_W, ADDR_W+1 (derived localparam, 6), pointer width including the wrap bit.

Ports:
clk  input  1  write-domain clock, rising edge
rst  input  1  asynchronous, active-high reset
winc  input  1  write request, sampled on clk
rgray_ip  input  PTR_W  read pointer, Gray-coded, asynchronous to clk
waddr  output  ADDR_W  RAM write address = wbin[ADDR_W-1:0]
wgray_op  output  PTR_W  registered Gray write pointer, sent to the read domain
wfull  output  1  FIFO full, registered
wovf  output  1  one-cycle pulse: winc seen while wfull=1
wlevel  output  PTR_W  write-side fill estimate, 0..2^ADDR_W

Behaviour:
- Reset is one clock and one reset, async active-high. While rst=1: wbin=0, wgray_op=0, rq1=0, rq2=0, wfull=0, wovf=0, hence waddr=0 and wlevel=0. Deassertion takes effect from the next rising edge.
- Write accept: wpush = winc & ~wfull.
- wbin_next = wbin + wpush, modulo 2^PTR_W.
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- On each clk edge: wbin <= wbin_next; wgray_op <= wgray_next. Only one bit of wgray_op ever toggles per edge; this property is mandatory.
- waddr comes from the current wbin. The RAM write on the accepting edge uses the pre-increment address.
- Synchronizer is two flops with no logic between them: rq1 <= rgray_ip; rq2 <= rq1. No other logic samples rgray_ip.
- Full: wfull <= (wgray_next == {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]}). It is registered, so wfull asserts on the same edge that accepts the write filling the last slot.
- Full release latency: a change on rgray_ip reaches rq2 after 2 edges and clears wfull on the 3rd edge.
- wovf <= winc & wfull. It is a single-cycle pulse per offending cycle. On overflow the pointer, Gray output and RAM address hold, and the data is dropped.
- Level: rbin_sync = Gray-to-binary of rq2, where bit k = XOR of rq2[PTR_W-1:k]. wlevel = wbin - rbin_sync, modulo 2^PTR_W, combinational from registers.
- The level is pessimistic: it may over-report by the synchronizer lag and never under-reports.
- Wrap-around: wbin 2^PTR_W-1 goes to 0, so wgray goes from 100000 to 000000 at the default width. Full and level stay correct across the wrap.
- Simultaneous winc and a read-pointer advance: the write is accepted if the registered wfull=0. The read advance is seen only after sync latency.
- Reset mid-operation clears all state immediately. No partial increment survives, and wovf is cleared.

Test Plan:
- Reset: assert rst with winc=1 toggling. Required: waddr=0, wgray_op=000000, wfull=0, wovf=0, wlevel=0 throughout, and after release until the first accepted write.
- Gray sequence: rgray_ip=0, winc=1 for 4 cycles. Required: wgray_op = 000001, 000011, 000010, 000110; waddr = 1, 2, 3, 4; exactly one bit changes per edge.
- Fill to full: rgray_ip=0, 32 consecutive writes. Required: wfull=1 after edge 32, wgray_op=110000, wlevel=32 (100000), waddr=0.
- Overflow: while full, winc=1 for 2 cycles. Required: wovf=1 for those 2 cycles, wgray_op and waddr unchanged, wfull stays 1.
- Release: from full, set rgray_ip=000001 (read ptr 1). Required: wfull still 1 after edges 1 and 2, wfull=0 after edge 3, wlevel=31.
- Wrap and reset: drive rgray_ip to track the write pointer until wbin reaches 63. Required: the next write gives wgray_op 100000 to 000000, and wfull never asserts. Then assert rst mid-stream. Required: all outputs return to 0 asynchronously, before the next clk edge.
